// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: pipeline stage register with valid/ready flow
// control, a 2-entry skid buffer, flush-to-bubble and a stall counter.
// Ports: clk, rst (async, active-low), flush;
//   upstream:   in_valid, in_ready (registered), in_ctrl, in_data, in_dst;
//   downstream: out_valid, out_ready, out_ctrl, out_data, out_dst;
//   stall_cnt: saturating count of cycles with out_valid & ~out_ready.
module pipe_stage_skid_reg #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]  in_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_dst,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic [CTRL_W-1:0]   main_ctrl_q;
    logic [DATA_W-1:0]   main_data_q;
    logic [REG_W-1:0]    main_dst_q;
    logic [CTRL_W-1:0]   skid_ctrl_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic [REG_W-1:0]    skid_dst_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                main_valid;
    logic                fire_in;
    logic                fire_out;

    assign main_valid = (state_q != EMPTY);
    assign fire_in    = in_valid & in_ready_q;
    assign fire_out   = main_valid & out_ready;

    // in_ready_q is the registered form of ~skid_valid, updated
    // alongside each state transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_dst_q  <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_dst_q  <= '0;
        end else if (flush) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (fire_in) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                        main_dst_q  <= in_dst;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (fire_in && fire_out) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                        main_dst_q  <= in_dst;
                    end else if (fire_in) begin
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                        skid_dst_q  <= in_dst;
                        state_q     <= TWO;
                        in_ready_q  <= 1'b0;
                    end else if (fire_out) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (fire_out) begin
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                        main_dst_q  <= skid_dst_q;
                        state_q     <= ONE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Saturating stall counter; flush does not clear it.
    always_comb begin
        cnt_d = cnt_q;
        if (main_valid && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    // Bubbles must never carry RegWrite/MemWrite downstream.
    assign out_ctrl  = main_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign out_dst   = main_dst_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Testbench for pipe_stage_skid_reg: directed vectors, scoreboard
// queue filled on accepted beats and drained by an output monitor.
`timescale 1ns/1ps
module tb_pipe_stage_skid_reg;

    localparam int CW = 3;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam int NW = 4;
    localparam int BW = CW + DW + RW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic [RW-1:0] in_dst = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_dst;
    logic [NW-1:0] stall_cnt;

    int vecs = 0;
    int miss = 0;
    logic [BW-1:0] sb_q[$];

    pipe_stage_skid_reg #(
        .CTRL_W(CW), .DATA_W(DW), .REG_W(RW), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_dst(out_dst),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk(input int d);
        logic [CW-1:0] c;
        logic [DW-1:0] x;
        logic [RW-1:0] r;
        c = CW'(d);
        x = {32'hCAFE0000 + 32'(d), 32'(d * 3)};
        r = RW'(d + 1);
        return {c, x, r};
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d);
        in_valid = 1'b1;
        {in_ctrl, in_data, in_dst} = mk(d);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: pop/compare delivered beats, then record
    // newly accepted beats; flush/reset discard everything held.
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", {out_ctrl, out_data, out_dst},
                        '1);
                end else begin
                    chk("sb_beat", {out_ctrl, out_data, out_dst},
                        sb_q.pop_front());
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back({in_ctrl, in_data, in_dst});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        chk("rst_out_bundle", {out_ctrl, out_data, out_dst}, '0);
        chk("rst_stall", BW'(stall_cnt), BW'(0));
        chk("rst_in_ready", BW'(in_ready), BW'(1));

        // 1: streaming, 1-cycle latency, in_ready stays high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(i);
            tick();
            chk("stream_valid", BW'(out_valid), BW'(1));
            chk("stream_beat", {out_ctrl, out_data, out_dst}, mk(i));
            chk("stream_in_ready", BW'(in_ready), BW'(1));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", BW'(out_valid), BW'(0));

        // 2: back-pressure A,B,C
        do_reset();
        out_ready = 1'b0;
        drive(10);
        tick();
        chk("bp_in_ready_a", BW'(in_ready), BW'(1));
        drive(11);
        tick();
        chk("bp_in_ready_b", BW'(in_ready), BW'(0));
        drive(12);
        repeat (3) tick();
        chk("bp_hold_a", {out_ctrl, out_data, out_dst}, mk(10));
        chk("bp_in_ready_c", BW'(in_ready), BW'(0));
        chk("bp_stall", BW'(stall_cnt), BW'(4));
        out_ready = 1'b1;
        tick();
        chk("bp_out_b", {out_ctrl, out_data, out_dst}, mk(11));
        tick();
        in_valid = 1'b0;
        chk("bp_out_c", {out_ctrl, out_data, out_dst}, mk(12));
        tick();
        chk("bp_empty", BW'(out_valid), BW'(0));
        chk("bp_stall_final", BW'(stall_cnt), BW'(4));

        // 3: flush in TWO while presenting X
        do_reset();
        out_ready = 1'b0;
        drive(20);
        tick();
        drive(21);
        tick();
        drive(22);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", BW'(out_valid), BW'(0));
        chk("fl_out_ctrl", BW'(out_ctrl), BW'(0));
        chk("fl_in_ready", BW'(in_ready), BW'(1));
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl_still_empty", BW'(out_valid), BW'(0));

        // 4: bubble masking of ctrl=3'b111
        do_reset();
        out_ready = 1'b1;
        drive(7);
        tick();
        in_valid = 1'b0;
        chk("bub_ctrl_live", BW'(out_ctrl), BW'(3'b111));
        tick();
        chk("bub_valid", BW'(out_valid), BW'(0));
        chk("bub_ctrl_zero", BW'(out_ctrl), BW'(0));

        // 5: async reset mid-cycle while in TWO
        do_reset();
        out_ready = 1'b0;
        drive(30);
        tick();
        drive(31);
        tick();
        in_valid = 1'b0;
        chk("ar_pre_ready", BW'(in_ready), BW'(0));
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", BW'(out_valid), BW'(0));
        chk("ar_bundle", {out_ctrl, out_data, out_dst}, '0);
        chk("ar_stall", BW'(stall_cnt), BW'(0));
        chk("ar_in_ready", BW'(in_ready), BW'(1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();

        // 6: stall counter saturation at 15
        out_ready = 1'b0;
        drive(40);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("sat_mid", BW'(stall_cnt), BW'(10));
        repeat (10) tick();
        chk("sat_top", BW'(stall_cnt), BW'(15));
        out_ready = 1'b1;
        repeat (2) tick();
        chk("sat_hold", BW'(stall_cnt), BW'(15));

        chk("sb_empty", BW'(sb_q.size()), BW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
